shiftreg_checker: RTL and testbench

// - Hardware checker downstream of shiftreg_wrap. Taps the words entering the shift register (ref_*)

---
 rtl/shiftreg_checker.sv | 216 +++++++++++++++++++++
 tb/tb_shiftreg_checker.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shiftreg_checker: in-order scoreboard comparing shift-register output words |
// | against the words that entered it; reports pass/fail and first-error data. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module shiftreg_checker #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_WORDS      = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic                                            start_i,
   input  logic                                            ref_valid_i,
   input  logic [DATA_WIDTH-1:0]                           ref_data_i,
   input  logic                                            dut_valid_i,
   input  logic [DATA_WIDTH-1:0]                           dut_data_i,
   output logic                                            busy_o,
   output logic                                            done_o,
   output logic                                            pass_o,
   output logic [$clog2(NUM_WORDS+1)-1:0]                  mismatch_cnt_o,
   output logic [((NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1)-1:0] first_err_idx_o,
   output logic [DATA_WIDTH-1:0]                           first_err_exp_o,
   output logic [DATA_WIDTH-1:0]                           first_err_got_o,
   output logic                                            overflow_o,
   output logic                                            underflow_o,
   output logic                                            timeout_o
);

   localparam int c_cnt_w = $clog2(NUM_WORDS + 1);
   localparam int c_idx_w = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_lvl_w = $clog2(FIFO_DEPTH + 1);
   localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic [c_lvl_w-1:0]    r_level;

   logic [c_idx_w-1:0]    r_idx;
   logic [c_cnt_w-1:0]    r_mis_cnt;
   logic [c_idx_w-1:0]    r_first_idx;
   logic [DATA_WIDTH-1:0] r_first_exp;
   logic [DATA_WIDTH-1:0] r_first_got;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  r_timeout;
   logic [c_tmr_w-1:0]    r_timer;

   logic                  w_run;
   logic                  w_start;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_bypass;
   logic                  w_under;
   logic                  w_check;
   logic                  w_push;
   logic                  w_drop;
   logic [DATA_WIDTH-1:0] w_exp;
   logic                  w_mis;
   logic                  w_last;
   logic [c_tmr_w-1:0]    w_tmr_nxt;
   logic                  w_tmo;
   logic [c_ptr_w-1:0]    w_wr_ptr_inc;
   logic [c_ptr_w-1:0]    w_rd_ptr_inc;

   assign w_run    = (r_state == ST_RUN);
   // start_i only arms a run from IDLE or DONE; a start during RUN is ignored
   assign w_start  = (r_state != ST_RUN) & start_i;
   assign w_full   = (r_level == c_lvl_w'(FIFO_DEPTH));
   assign w_empty  = (r_level == '0);

   assign w_check  = w_run & dut_valid_i;
   assign w_pop    = w_check & ~w_empty;
   assign w_bypass = w_check & w_empty & ref_valid_i;
   assign w_under  = w_check & w_empty & ~ref_valid_i;
   assign w_push   = w_run & ref_valid_i & ~w_bypass & (~w_full | w_pop);
   assign w_drop   = w_run & ref_valid_i & w_full & ~w_pop;

   // An underflowing word is compared against zero so first_err_exp_o reads 0
   assign w_exp    = w_pop    ? r_mem[r_rd_ptr] :
                     w_bypass ? ref_data_i      : '0;
   assign w_mis    = w_check & (w_under | (w_exp != dut_data_i));
   assign w_last   = w_check & (r_idx == c_idx_w'(NUM_WORDS - 1));

   assign w_tmr_nxt = r_timer + c_tmr_w'(1);
   assign w_tmo     = w_run & ~dut_valid_i & (w_tmr_nxt == c_tmr_w'(TIMEOUT_CYCLES));

   assign w_wr_ptr_inc = (r_wr_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + c_ptr_w'(1);
   assign w_rd_ptr_inc = (r_rd_ptr == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + c_ptr_w'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy_o = 1'b1;
            if (w_last || w_tmo) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done_o = 1'b1;
            if (start_i) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= ref_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || w_start) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= w_wr_ptr_inc;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_inc;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_lvl_w'(1);
            2'b01:   r_level <= r_level - c_lvl_w'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || w_start) begin
         r_idx       <= '0;
         r_mis_cnt   <= '0;
         r_first_idx <= '0;
         r_first_exp <= '0;
         r_first_got <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_timeout   <= 1'b0;
         r_timer     <= '0;
      end else if (w_run) begin
         r_timer <= dut_valid_i ? '0 : w_tmr_nxt;
         if (w_check) begin
            r_idx <= r_idx + c_idx_w'(1);
         end
         if (w_mis) begin
            if (r_mis_cnt != c_cnt_w'(NUM_WORDS)) begin
               r_mis_cnt <= r_mis_cnt + c_cnt_w'(1);
            end
            // A zero count means no earlier mismatch in this run
            if (r_mis_cnt == '0) begin
               r_first_idx <= r_idx;
               r_first_exp <= w_exp;
               r_first_got <= dut_data_i;
            end
         end
         if (w_under) begin
            r_underflow <= 1'b1;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_tmo) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign mismatch_cnt_o  = r_mis_cnt;
   assign first_err_idx_o = r_first_idx;
   assign first_err_exp_o = r_first_exp;
   assign first_err_got_o = r_first_got;
   assign overflow_o      = r_overflow;
   assign underflow_o     = r_underflow;
   assign timeout_o       = r_timeout;
   assign pass_o          = done_o & (r_mis_cnt == '0) & ~r_overflow & ~r_underflow & ~r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shiftreg_checker: randomized and directed runs against a queue model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_shiftreg_checker;

   localparam int DW = 32;
   localparam int NW = 4;
   localparam int FD = 8;
   localparam int TO = 64;
   localparam int CW = $clog2(NW + 1);
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          ref_valid_i;
   logic [DW-1:0] ref_data_i;
   logic          dut_valid_i;
   logic [DW-1:0] dut_data_i;
   logic          busy_o;
   logic          done_o;
   logic          pass_o;
   logic [CW-1:0] mismatch_cnt_o;
   logic [IW-1:0] first_err_idx_o;
   logic [DW-1:0] first_err_exp_o;
   logic [DW-1:0] first_err_got_o;
   logic          overflow_o;
   logic          underflow_o;
   logic          timeout_o;

   shiftreg_checker #(
      .DATA_WIDTH    (DW),
      .NUM_WORDS     (NW),
      .FIFO_DEPTH    (FD),
      .TIMEOUT_CYCLES(TO)
   ) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .ref_valid_i    (ref_valid_i),
      .ref_data_i     (ref_data_i),
      .dut_valid_i    (dut_valid_i),
      .dut_data_i     (dut_data_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .pass_o         (pass_o),
      .mismatch_cnt_o (mismatch_cnt_o),
      .first_err_idx_o(first_err_idx_o),
      .first_err_exp_o(first_err_exp_o),
      .first_err_got_o(first_err_got_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          rv;
      logic [DW-1:0] rd;
      logic          dv;
      logic [DW-1:0] dd;
   } cyc_t;

   typedef struct {
      int            cnt;
      int            idx;
      logic [DW-1:0] exp;
      logic [DW-1:0] got;
      bit            ovf;
      bit            unf;
      bit            tmo;
      bit            pass;
      int            cycles;
   } res_t;

   cyc_t stim[$];
   res_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   mon_prev_done = 1'b0;
   int   mon_busy_cnt  = 0;

   logic [DW-1:0] words [4] = '{32'hA5A50000, 32'h0BADF00D, 32'h12345678, 32'hCAFEBABE};
   logic [DW-1:0] rnd   [9];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},     64'(busy_o),          64'(0));
      chk({tag, "_done"},     64'(done_o),          64'(0));
      chk({tag, "_pass"},     64'(pass_o),          64'(0));
      chk({tag, "_mis_cnt"},  64'(mismatch_cnt_o),  64'(0));
      chk({tag, "_err_idx"},  64'(first_err_idx_o), 64'(0));
      chk({tag, "_err_exp"},  64'(first_err_exp_o), 64'(0));
      chk({tag, "_err_got"},  64'(first_err_got_o), 64'(0));
      chk({tag, "_overflow"}, 64'(overflow_o),      64'(0));
      chk({tag, "_underflow"},64'(underflow_o),     64'(0));
      chk({tag, "_timeout"},  64'(timeout_o),       64'(0));
   endtask

   // Reference: queue of expected words; a run ends after NW checks or TO idle cycles
   task automatic run_model(output res_t r);
      logic [DW-1:0] q[$];
      logic [DW-1:0] e;
      cyc_t c;
      int   nwords;
      int   idle;
      int   i;
      bit   bypass;
      bit   unf_now;
      r = '{default: 0};
      nwords = 0;
      idle = 0;
      i = 0;
      while (1) begin
         if (i < stim.size()) c = stim[i];
         else c = '{default: 0};
         bypass = 0;
         unf_now = 0;
         if (c.dv) begin
            if (q.size() > 0) e = q.pop_front();
            else if (c.rv) begin e = c.rd; bypass = 1; end
            else begin e = '0; unf_now = 1; r.unf = 1; end
            if (unf_now || e != c.dd) begin
               if (r.cnt == 0) begin r.idx = nwords; r.exp = e; r.got = c.dd; end
               if (r.cnt < NW) r.cnt++;
            end
            nwords++;
            idle = 0;
         end else begin
            idle++;
         end
         if (c.rv && !bypass) begin
            if (q.size() < FD) q.push_back(c.rd);
            else r.ovf = 1;
         end
         i++;
         if (nwords == NW) break;
         if (idle == TO) begin r.tmo = 1; break; end
      end
      r.cycles = i;
      r.pass = (r.cnt == 0) && !r.ovf && !r.unf && !r.tmo;
   endtask

   task automatic drive(input cyc_t c);
      ref_valid_i = c.rv;
      ref_data_i  = c.rd;
      dut_valid_i = c.dv;
      dut_data_i  = c.dd;
   endtask

   task automatic add(input logic rv, input logic [DW-1:0] rd, input logic dv, input logic [DW-1:0] dd);
      cyc_t c;
      c.rv = rv; c.rd = rd; c.dv = dv; c.dd = dd;
      stim.push_back(c);
   endtask

   task automatic run_one();
      res_t r;
      cyc_t c;
      run_model(r);
      sb_q.push_back(r);
      @(posedge clk_i); #1;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk("start_busy",      64'(busy_o),         64'(1));
      chk("start_done",      64'(done_o),         64'(0));
      chk("start_mis_cnt",   64'(mismatch_cnt_o), 64'(0));
      chk("start_err_got",   64'(first_err_got_o),64'(0));
      chk("start_flags",     64'({overflow_o, underflow_o, timeout_o}), 64'(0));
      for (int i = 0; i < r.cycles; i++) begin
         if (i < stim.size()) c = stim[i];
         else c = '{default: 0};
         drive(c);
         @(posedge clk_i); #1;
      end
      drive('{default: 0});
      @(posedge clk_i); #1;
   endtask

   // Monitor: each rising done_o retires one expected result
   initial begin
      res_t e;
      forever begin
         @(negedge clk_i);
         if (busy_o) mon_busy_cnt++;
         if (done_o && !mon_prev_done) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
               e = sb_q.pop_front();
               chk("run_cycles", 64'(mon_busy_cnt),     64'(e.cycles));
               chk("pass",       64'(pass_o),           64'(e.pass));
               chk("mis_cnt",    64'(mismatch_cnt_o),   64'(e.cnt));
               chk("err_idx",    64'(first_err_idx_o),  64'(e.idx));
               chk("err_exp",    64'(first_err_exp_o),  64'(e.exp));
               chk("err_got",    64'(first_err_got_o),  64'(e.got));
               chk("overflow",   64'(overflow_o),       64'(e.ovf));
               chk("underflow",  64'(underflow_o),      64'(e.unf));
               chk("timeout",    64'(timeout_o),        64'(e.tmo));
            end
         end
         if (!busy_o) mon_busy_cnt = 0;
         mon_prev_done = done_o;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int ci;
      logic [DW-1:0] sent[$];
      cyc_t c;
      rst_i = 1'b1; start_i = 1'b0;
      drive('{default: 0});
      repeat (5) @(posedge clk_i);
      #1;
      chk_all_zero("reset");
      rst_i = 1'b0;
      foreach (rnd[k]) rnd[k] = $urandom;

      // Clean run, then same run with word 2 corrupted
      for (int bad = 0; bad < 2; bad++) begin
         stim.delete();
         for (int t = 0; t < 8; t++) begin
            if (t < 4) add(1'b1, words[t], 1'b0, '0);
            else add(1'b0, '0, 1'b1, (bad == 1 && t == 6) ? 32'hDEADBEEF : words[t-4]);
         end
         run_one();
      end

      // Underflow on the first word, then bypassed words
      stim.delete();
      add(1'b0, '0, 1'b1, rnd[0]);
      for (int t = 1; t < 4; t++) add(1'b1, rnd[t], 1'b1, rnd[t]);
      run_one();

      // Bypass only
      stim.delete();
      for (int t = 0; t < 4; t++) add(1'b1, rnd[t+4], 1'b1, rnd[t+4]);
      run_one();

      // Nine refs with no pop overflow an 8-deep FIFO
      stim.delete();
      for (int t = 0; t < 9; t++) add(1'b1, rnd[t], 1'b0, '0);
      for (int t = 0; t < 4; t++) add(1'b0, '0, 1'b1, rnd[t]);
      run_one();

      // Ninth ref alongside a pop fits
      stim.delete();
      for (int t = 0; t < 8; t++) add(1'b1, rnd[t], 1'b0, '0);
      add(1'b1, rnd[8], 1'b1, rnd[0]);
      for (int t = 1; t < 4; t++) add(1'b0, '0, 1'b1, rnd[t]);
      run_one();

      // No output words at all
      stim.delete();
      run_one();

      // Randomized traffic with occasional corruption
      for (int run = 0; run < 20; run++) begin
         stim.delete();
         sent.delete();
         ci = 0;
         len = $urandom_range(8, 40);
         for (int t = 0; t < len; t++) begin
            c.rv = 1'($urandom_range(0, 1));
            c.rd = $urandom;
            c.dv = ($urandom_range(0, 2) == 0);
            c.dd = '0;
            if (c.rv) sent.push_back(c.rd);
            if (c.dv) begin
               c.dd = (ci < sent.size()) ? sent[ci] : $urandom;
               ci++;
               if ($urandom_range(0, 9) == 0) c.dd = c.dd ^ (32'h1 << $urandom_range(0, 31));
            end
            stim.push_back(c);
         end
         run_one();
      end

      // Mid-run reset after two words, one of them wrong
      @(posedge clk_i); #1;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      c = '{rv: 1'b1, rd: words[0], dv: 1'b0, dd: '0};
      drive(c);
      @(posedge clk_i); #1;
      c = '{rv: 1'b1, rd: words[1], dv: 1'b1, dd: ~words[0]};
      drive(c);
      @(posedge clk_i); #1;
      c = '{rv: 1'b0, rd: '0, dv: 1'b1, dd: words[1]};
      drive(c);
      @(posedge clk_i); #1;
      drive('{default: 0});
      chk("midrun_mis_cnt", 64'(mismatch_cnt_o), 64'(1));
      chk("midrun_busy",    64'(busy_o),         64'(1));
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk_all_zero("midrst");
      rst_i = 1'b1; start_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0; start_i = 1'b0;
      chk("rst_beats_start", 64'(busy_o), 64'(0));
      c = '{rv: 1'b0, rd: '0, dv: 1'b1, dd: rnd[0]};
      drive(c);
      repeat (3) @(posedge clk_i);
      #1;
      drive('{default: 0});
      chk_all_zero("idle_ignore");

      stim.delete();
      for (int t = 0; t < 8; t++) begin
         if (t < 4) add(1'b1, words[t], 1'b0, '0);
         else add(1'b0, '0, 1'b1, words[t-4]);
      end
      run_one();

      repeat (4) @(posedge clk_i);
      #1;
      chk("sb_drain", 64'(sb_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
